// File: rtl/npc_sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : npc_sim_ctrl
// Purpose  : Run controller for the NPC simulation harness. It sequences the
//            core reset, counts RUN cycles and retired instructions, detects
//            good/bad traps, global timeout and commit stalls, and latches a
//            sticky final status word.
// Revision : 1.0 - initial release
// ============================================================================
module npc_sim_ctrl #(
    parameter int unsigned RESET_CYCLES   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 300000,
    parameter int unsigned STALL_LIMIT    = 4096,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit,
    input  logic [31:0]      commit_pc,
    input  logic             halt,
    input  logic [31:0]      halt_code,
    output logic             dut_reset,
    output logic             running,
    output logic             done,
    output logic [2:0]       status,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [31:0]      last_pc
);

    // Reset down-counter only has to hold RESET_CYCLES-1.
    localparam int unsigned        RST_W      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_W-1:0]   RST_LOAD   = RST_W'(RESET_CYCLES - 1);
    // Stall counter width is clog2(STALL_LIMIT+1), kept at least one bit wide.
    localparam int unsigned        STL_W      = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [STL_W-1:0]   STALL_LAST = STL_W'((STALL_LIMIT > 0) ? (STALL_LIMIT - 1) : 0);
    localparam logic [63:0]        TIMEOUT_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_GOOD    = 3'd1;
    localparam logic [2:0] ST_BAD     = 3'd2;
    localparam logic [2:0] ST_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_STALL   = 3'd4;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             armed_q,   armed_d;
    logic [STL_W-1:0] stall_q,   stall_d;
    logic [CNT_W-1:0] cycle_q,   cycle_d;
    logic [CNT_W-1:0] inst_q,    inst_d;
    logic [31:0]      pc_q,      pc_d;
    logic [2:0]       status_q,  status_d;

    logic [63:0]      cyc_ext;
    logic             timeout_hit;
    logic             stall_hit;

    assign cyc_ext     = 64'(cycle_q);
    // Both checks look at the value before this cycle's increment, so the
    // event lands on the edge where the count reaches its limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cyc_ext == TIMEOUT_LAST);
    assign stall_hit   = (STALL_LIMIT != 0) && !commit && (stall_q == STALL_LAST);

    // Next-state, counter and status logic for the RST/RUN/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        armed_d   = armed_q;
        stall_d   = stall_q;
        cycle_d   = cycle_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        status_d  = status_q;

        case (state_q)
            S_RST: begin
                // The first released edge only arms the counter, so the core
                // sees RESET_CYCLES full edges of reset after release.
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (rst_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RST_W'(1);
                end
            end

            S_RUN: begin
                if (cycle_q != CNT_MAX) begin
                    cycle_d = cycle_q + CNT_W'(1);
                end
                if (commit) begin
                    if (inst_q != CNT_MAX) begin
                        inst_d = inst_q + CNT_W'(1);
                    end
                    pc_d    = commit_pc;
                    stall_d = '0;
                end else if (stall_q != '1) begin
                    stall_d = stall_q + STL_W'(1);
                end

                if (halt) begin
                    status_d = (halt_code == 32'd0) ? ST_GOOD : ST_BAD;
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end else if (stall_hit) begin
                    status_d = ST_STALL;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_RST;
            rst_cnt_q <= RST_LOAD;
            armed_q   <= 1'b0;
            stall_q   <= '0;
            cycle_q   <= '0;
            inst_q    <= '0;
            pc_q      <= '0;
            status_q  <= ST_NONE;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            armed_q   <= armed_d;
            stall_q   <= stall_d;
            cycle_q   <= cycle_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            status_q  <= status_d;
        end
    end

    // Outputs decode only registered state; no input reaches them directly.
    assign dut_reset = (state_q == S_RST);
    assign running   = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign status    = status_q;
    assign cycle_cnt = cycle_q;
    assign inst_cnt  = inst_q;
    assign last_pc   = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_npc_sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_sim_ctrl
// Purpose  : Self-checking bench for npc_sim_ctrl. Four instances with
//            different parameter sets are driven by directed scenarios and
//            random traffic and compared each cycle to a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npc_sim_ctrl;

    localparam int N = 4;
    localparam int P_RC [N] = '{3, 2, 1, 3};
    localparam int P_TO [N] = '{300000, 100, 0, 0};
    localparam int P_SL [N] = '{4096, 0, 8, 8};
    localparam int P_CW [N] = '{32, 32, 32, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]        r_rst, r_commit, r_halt;
    logic [N-1:0][31:0]  r_pc, r_code;
    logic [N-1:0]        w_dres, w_run, w_done;
    logic [N-1:0][2:0]   w_st;
    logic [N-1:0][31:0]  w_cyc, w_ins, w_lpc;

    assign w_cyc[3][31:4] = '0;
    assign w_ins[3][31:4] = '0;

    npc_sim_ctrl #(.RESET_CYCLES(3), .TIMEOUT_CYCLES(300000), .STALL_LIMIT(4096), .CNT_W(32)) u_dut0 (
        .clock(clk), .reset(r_rst[0]), .commit(r_commit[0]), .commit_pc(r_pc[0]),
        .halt(r_halt[0]), .halt_code(r_code[0]), .dut_reset(w_dres[0]), .running(w_run[0]),
        .done(w_done[0]), .status(w_st[0]), .cycle_cnt(w_cyc[0]), .inst_cnt(w_ins[0]),
        .last_pc(w_lpc[0]));

    npc_sim_ctrl #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(100), .STALL_LIMIT(0), .CNT_W(32)) u_dut1 (
        .clock(clk), .reset(r_rst[1]), .commit(r_commit[1]), .commit_pc(r_pc[1]),
        .halt(r_halt[1]), .halt_code(r_code[1]), .dut_reset(w_dres[1]), .running(w_run[1]),
        .done(w_done[1]), .status(w_st[1]), .cycle_cnt(w_cyc[1]), .inst_cnt(w_ins[1]),
        .last_pc(w_lpc[1]));

    npc_sim_ctrl #(.RESET_CYCLES(1), .TIMEOUT_CYCLES(0), .STALL_LIMIT(8), .CNT_W(32)) u_dut2 (
        .clock(clk), .reset(r_rst[2]), .commit(r_commit[2]), .commit_pc(r_pc[2]),
        .halt(r_halt[2]), .halt_code(r_code[2]), .dut_reset(w_dres[2]), .running(w_run[2]),
        .done(w_done[2]), .status(w_st[2]), .cycle_cnt(w_cyc[2]), .inst_cnt(w_ins[2]),
        .last_pc(w_lpc[2]));

    npc_sim_ctrl #(.RESET_CYCLES(3), .TIMEOUT_CYCLES(0), .STALL_LIMIT(8), .CNT_W(4)) u_dut3 (
        .clock(clk), .reset(r_rst[3]), .commit(r_commit[3]), .commit_pc(r_pc[3]),
        .halt(r_halt[3]), .halt_code(r_code[3]), .dut_reset(w_dres[3]), .running(w_run[3]),
        .done(w_done[3]), .status(w_st[3]), .cycle_cnt(w_cyc[3][3:0]), .inst_cnt(w_ins[3][3:0]),
        .last_pc(w_lpc[3]));

    // Reference model: phase 0 = core in reset, 1 = running, 2 = finished.
    int          m_ph   [N];
    int          m_rel  [N];
    int          m_st   [N];
    longint      m_cyc  [N];
    longint      m_ins  [N];
    longint      m_runs [N];
    longint      m_free [N];
    logic [31:0] m_pc   [N];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step(input int i);
        longint mx;
        mx = (longint'(1) << P_CW[i]) - 1;
        if (r_rst[i]) begin
            m_ph[i] = 0; m_rel[i] = 0; m_st[i] = 0; m_cyc[i] = 0; m_ins[i] = 0;
            m_runs[i] = 0; m_free[i] = 0; m_pc[i] = '0;
        end else if (m_ph[i] == 0) begin
            m_rel[i]++;
            if (m_rel[i] > P_RC[i]) m_ph[i] = 1;
        end else if (m_ph[i] == 1) begin
            m_runs[i]++;
            if (m_cyc[i] < mx) m_cyc[i]++;
            if (r_commit[i]) begin
                if (m_ins[i] < mx) m_ins[i]++;
                m_pc[i]   = r_pc[i];
                m_free[i] = 0;
            end else begin
                m_free[i]++;
            end
            if (r_halt[i]) begin
                m_st[i] = (r_code[i] == 0) ? 1 : 2;
                m_ph[i] = 2;
            end else if (P_TO[i] != 0 && m_runs[i] == P_TO[i]) begin
                m_st[i] = 3;
                m_ph[i] = 2;
            end else if (P_SL[i] != 0 && m_free[i] == P_SL[i]) begin
                m_st[i] = 4;
                m_ph[i] = 2;
            end
        end
    endtask

    // Advance one clock: update the model from the sampled inputs, then
    // compare every instance just after the edge.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i);
        #1;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("u%0d.dut_reset", i), w_dres[i], (m_ph[i] == 0));
                check($sformatf("u%0d.running", i), w_run[i], (m_ph[i] == 1));
                check($sformatf("u%0d.done", i), w_done[i], (m_ph[i] == 2));
                check($sformatf("u%0d.status", i), w_st[i], m_st[i]);
                check($sformatf("u%0d.cycle_cnt", i), w_cyc[i], m_cyc[i]);
                check($sformatf("u%0d.inst_cnt", i), w_ins[i], m_ins[i]);
                check($sformatf("u%0d.last_pc", i), w_lpc[i], m_pc[i]);
            end
        end
    endtask

    task automatic idle(input int i);
        r_commit[i] = 1'b0; r_halt[i] = 1'b0; r_pc[i] = '0; r_code[i] = '0;
    endtask

    // Reset one instance and bring it to RUN with cycle_cnt still 0.
    task automatic start_run(input int i);
        idle(i);
        r_rst[i] = 1'b1;
        tick(); tick();
        r_rst[i] = 1'b0;
        repeat (P_RC[i] + 1) tick();
        check("start.running", w_run[i], 1);
    endtask

    initial begin
        r_rst = '1; r_commit = '0; r_halt = '0; r_pc = '0; r_code = '0;
        repeat (5) tick();
        chk_en = 1'b1;

        // Reset values
        check("rst.dut_reset", w_dres[0], 1);
        check("rst.running", w_run[0], 0);
        check("rst.done", w_done[0], 0);
        check("rst.status", w_st[0], 0);
        check("rst.cycle_cnt", w_cyc[0], 0);
        check("rst.inst_cnt", w_ins[0], 0);
        check("rst.last_pc", w_lpc[0], 0);

        // Reset sequencing: three more edges of dut_reset, then RUN
        r_rst = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("seq.dut_reset", w_dres[0], 1);
            check("seq.running", w_run[0], 0);
        end
        tick();
        check("seq.run", w_run[0], 1);
        check("seq.dut_reset_low", w_dres[0], 0);
        check("seq.cyc0", w_cyc[0], 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("seq.cyc", w_cyc[0], k);
        end

        // Good trap
        start_run(0);
        for (int c = 0; c < 20; c++) begin
            r_commit[0] = (c % 2 == 0);
            r_pc[0] = 32'h8000_0000 + 32'(4 * (c / 2));
            tick();
        end
        r_commit[0] = 1'b0; r_halt[0] = 1'b1; r_code[0] = 32'd0;
        tick();
        idle(0);
        check("good.status", w_st[0], 1);
        check("good.inst_cnt", w_ins[0], 10);
        check("good.last_pc", w_lpc[0], 32'h8000_0024);
        check("good.cycle_cnt", w_cyc[0], 21);
        check("good.done", w_done[0], 1);
        for (int c = 0; c < 50; c++) begin
            r_commit[0] = 1'($urandom_range(0, 1));
            r_pc[0] = $urandom;
            r_halt[0] = 1'($urandom_range(0, 1));
            r_code[0] = $urandom_range(0, 3);
            tick();
        end
        idle(0);
        check("frz.status", w_st[0], 1);
        check("frz.inst_cnt", w_ins[0], 10);
        check("frz.last_pc", w_lpc[0], 32'h8000_0024);
        check("frz.cycle_cnt", w_cyc[0], 21);
        check("frz.done", w_done[0], 1);

        // Bad trap with a commit in the same cycle
        start_run(0);
        for (int c = 0; c < 3; c++) begin
            r_commit[0] = 1'b1; r_pc[0] = 32'h8000_0000 + 32'(4 * c);
            tick();
        end
        r_commit[0] = 1'b1; r_pc[0] = 32'h8000_0100; r_halt[0] = 1'b1; r_code[0] = 32'd1;
        tick();
        idle(0);
        check("bad.status", w_st[0], 2);
        check("bad.inst_cnt", w_ins[0], 4);
        check("bad.last_pc", w_lpc[0], 32'h8000_0100);
        check("bad.cycle_cnt", w_cyc[0], 4);

        // Mid-run reset
        start_run(0);
        for (int c = 0; c < 40; c++) begin
            r_commit[0] = 1'($urandom_range(0, 1)); r_pc[0] = $urandom;
            tick();
        end
        idle(0);
        r_rst[0] = 1'b1;
        tick();
        check("mid.dut_reset", w_dres[0], 1);
        check("mid.running", w_run[0], 0);
        check("mid.cycle_cnt", w_cyc[0], 0);
        check("mid.inst_cnt", w_ins[0], 0);
        check("mid.last_pc", w_lpc[0], 0);
        check("mid.status", w_st[0], 0);
        r_rst[0] = 1'b0;
        repeat (3) begin
            tick();
            check("mid.seq_dut_reset", w_dres[0], 1);
        end
        tick();
        check("mid.rerun", w_run[0], 1);
        repeat (5) tick();
        check("mid.cycle_cnt5", w_cyc[0], 5);

        // Timeout with commits every cycle
        start_run(1);
        r_commit[1] = 1'b1;
        for (int c = 0; c < 99; c++) begin
            r_pc[1] = 32'h8000_0000 + 32'(4 * c);
            tick();
        end
        check("to.still_running", w_run[1], 1);
        tick();
        idle(1);
        check("to.status", w_st[1], 3);
        check("to.cycle_cnt", w_cyc[1], 100);
        check("to.inst_cnt", w_ins[1], 100);
        check("to.done", w_done[1], 1);

        // Halt on the timeout cycle wins
        start_run(1);
        r_commit[1] = 1'b1;
        repeat (99) tick();
        r_halt[1] = 1'b1; r_code[1] = 32'd0;
        tick();
        idle(1);
        check("tohalt.status", w_st[1], 1);
        check("tohalt.cycle_cnt", w_cyc[1], 100);

        // Stall after commits stop
        start_run(2);
        r_commit[2] = 1'b1;
        repeat (6) tick();
        r_commit[2] = 1'b0;
        repeat (7) tick();
        check("stall.not_yet", w_run[2], 1);
        tick();
        check("stall.status", w_st[2], 4);
        check("stall.done", w_done[2], 1);
        check("stall.cycle_cnt", w_cyc[2], 14);
        check("stall.inst_cnt", w_ins[2], 6);

        // Saturation on the 4-bit instance
        start_run(3);
        r_commit[3] = 1'b1;
        repeat (20) tick();
        check("sat.inst_cnt", w_ins[3], 15);
        check("sat.cycle_cnt", w_cyc[3], 15);
        check("sat.running", w_run[3], 1);
        r_commit[3] = 1'b0;
        repeat (8) tick();
        check("sat.status", w_st[3], 4);
        check("sat.cycle_final", w_cyc[3], 15);

        // Random traffic against the model
        for (int ep = 0; ep < 12; ep++) begin
            int i, n, p;
            i = ep % N;
            start_run(i);
            n = $urandom_range(40, 250);
            p = $urandom_range(1, 8);
            for (int c = 0; c < n; c++) begin
                r_commit[i] = ($urandom_range(0, 7) < p);
                r_pc[i]     = $urandom;
                r_halt[i]   = ($urandom_range(0, 99) == 0);
                r_code[i]   = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
                r_rst[i]    = ($urandom_range(0, 199) == 0);
                tick();
            end
            idle(i);
            r_rst[i] = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
